// File: rtl/cache_way_array_pkg.sv
// rtl/cache_way_array_pkg.sv - shared types and constants for the cache way array
//
// Purpose: sweep FSM state encoding, default geometry helpers and the request
// bundle type used by controller-side code talking to cache_way_array.
// Ports: none (package).

package cache_way_array_pkg;

  // Encodings kept as plain constants so legacy code can compare raw state bits.
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    INIT  = ST_INIT,
    IDLE  = ST_IDLE,
    FLUSH = ST_FLUSH
  } cache_way_array_state_t;

  // Default geometry: 32-bit byte address, 1024 sets, 2 ways, 32-bit lines.
  localparam int DEF_ADDRESS_WIDTH   = 32;
  localparam int DEF_SETS            = 1024;
  localparam int DEF_WAYS            = 2;
  localparam int DEF_CACHE_LINE_SIZE = 32;

  localparam int OFFSET_BITS   = $clog2(DEF_CACHE_LINE_SIZE / 8);
  localparam int SET_BITS      = $clog2(DEF_SETS);
  localparam int DEF_TAG_WIDTH = DEF_ADDRESS_WIDTH - (SET_BITS + OFFSET_BITS);

  // Request fields for the default geometry, bundled for controller-side code.
  typedef struct packed {
    logic [DEF_ADDRESS_WIDTH-1:0]       addr;
    logic [DEF_WAYS-1:0]                wen_data;
    logic [DEF_WAYS-1:0]                wen_tag;
    logic [DEF_CACHE_LINE_SIZE/8-1:0]   strobe;
    logic [DEF_CACHE_LINE_SIZE-1:0]     data;
    logic [DEF_TAG_WIDTH-1:0]           tag;
    logic [DEF_WAYS-1:0][1:0]           valid_dirty;
  } way_req_t;

endpackage

// File: rtl/cache_sram_bank.sv
// rtl/cache_sram_bank.sv - single-port read-first SRAM bank with byte-lane strobes
//
// Purpose: DEPTH x WIDTH storage with a registered 1-cycle read. A read and a
// write to the same address at the same edge return the old contents.
// Ports:
//   clk      in   clock
//   rst_n    in   async active-low reset (clears the read register only)
//   i_ren    in   capture r_mem[i_addr] into o_rdata at the next edge
//   i_wen    in   write enable
//   i_addr   in   word address
//   i_strb   in   per-lane write enables (STRB_W lanes of WIDTH/STRB_W bits)
//   i_wdata  in   write data
//   o_rdata  out  registered read data, held until the next i_ren

module cache_sram_bank #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int STRB_W = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ren,
  input  logic              i_wen,
  input  logic [AW-1:0]     i_addr,
  input  logic [STRB_W-1:0] i_strb,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int LANE = WIDTH / STRB_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage carries no reset so it maps onto a real SRAM macro.
  always_ff @(posedge clk) begin
    if (i_wen) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_strb[b]) begin
          r_mem[i_addr][b*LANE +: LANE] <= i_wdata[b*LANE +: LANE];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_ren) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - flushable WAYS x SETS tag/valid-dirty/data array
//
// Purpose: storage array for the set-associative cache with a valid/ready
// request port, registered response, post-reset init sweep and flush sweep.
// Optional feature macro: CACHE_WAY_ARRAY_PARITY_EN (tag/valid-dirty parity).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid / req_ready       request handshake
//   req_addr                    byte address; set = addr[offset bits +: set bits]
//   req_wen_data / req_wen_tag  per-way data / tag+valid-dirty write enables
//   req_strobe, req_data        byte enables and write data for the line
//   req_tag, req_valid_dirty    tag (all ways) and per-way {dirty,valid}
//   rsp_valid                   response registers updated this cycle
//   rsp_data/tag/valid_dirty    per-way read-first contents of the set
//   rsp_parity_err              per-way parity mismatch (0 without the macro)
//   flush_req                   start an invalidate-all sweep
//   flush_busy, flush_done      sweep in progress / end-of-sweep pulse

module cache_way_array
  import cache_way_array_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int SETS            = 1024,
  parameter int WAYS            = 2,
  parameter int CACHE_LINE_SIZE = 32,
  parameter int TAG_WIDTH       = ADDRESS_WIDTH - ($clog2(SETS) + $clog2(CACHE_LINE_SIZE/8))
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDRESS_WIDTH-1:0]              req_addr,
  input  logic [WAYS-1:0]                       req_wen_data,
  input  logic [WAYS-1:0]                       req_wen_tag,
  input  logic [CACHE_LINE_SIZE/8-1:0]          req_strobe,
  input  logic [CACHE_LINE_SIZE-1:0]            req_data,
  input  logic [TAG_WIDTH-1:0]                  req_tag,
  input  logic [WAYS-1:0][1:0]                  req_valid_dirty,
  output logic                                  rsp_valid,
  output logic [WAYS-1:0][CACHE_LINE_SIZE-1:0]  rsp_data,
  output logic [WAYS-1:0][TAG_WIDTH-1:0]        rsp_tag,
  output logic [WAYS-1:0][1:0]                  rsp_valid_dirty,
  output logic [WAYS-1:0]                       rsp_parity_err,
  input  logic                                  flush_req,
  output logic                                  flush_busy,
  output logic                                  flush_done
);

  localparam int OFF_B  = $clog2(CACHE_LINE_SIZE / 8);
  localparam int SET_B  = $clog2(SETS);
  localparam int STRB_W = CACHE_LINE_SIZE / 8;

`ifdef CACHE_WAY_ARRAY_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int TAG_SW = TAG_WIDTH + PAR_W;
  localparam int VD_SW  = 2 + PAR_W;

  cache_way_array_state_t r_state;
  logic [SET_B-1:0]       r_set_cnt;
  logic                   r_flush_done;
  logic                   r_rsp_valid;

  logic                   w_sweep;
  logic                   w_last_set;
  logic                   w_accept;
  logic [SET_B-1:0]       w_req_set;
  logic [SET_B-1:0]       w_addr;

  assign w_sweep    = (r_state == INIT) || (r_state == FLUSH);
  assign w_last_set = (r_set_cnt == SET_B'(SETS - 1));
  // A same-cycle flush request blocks acceptance so the sweep starts on clean state.
  assign req_ready  = (r_state == IDLE) && !flush_req;
  assign w_accept   = req_valid && req_ready;
  assign w_req_set  = req_addr[OFF_B +: SET_B];
  // Sweeps and requests are mutually exclusive, so one address mux serves all banks.
  assign w_addr     = w_sweep ? r_set_cnt : w_req_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= INIT;
      r_set_cnt    <= '0;
      r_flush_done <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_rsp_valid  <= w_accept;
      r_flush_done <= w_sweep && w_last_set;
      case (r_state)
        INIT, FLUSH: begin
          if (w_last_set) begin
            r_state   <= IDLE;
            r_set_cnt <= '0;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (flush_req) begin
            r_state   <= FLUSH;
            r_set_cnt <= '0;
          end
        end
        default: begin
          r_state   <= INIT;
          r_set_cnt <= '0;
        end
      endcase
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign flush_busy = w_sweep;
  assign flush_done = r_flush_done;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_SW-1:0] w_tag_wdata;
    logic [TAG_SW-1:0] w_tag_q;
    logic [VD_SW-1:0]  w_vd_wdata;
    logic [VD_SW-1:0]  w_vd_q;
    logic              w_vd_wen;

`ifdef CACHE_WAY_ARRAY_PARITY_EN
    // Parity is split into a tag half (stored with the tag) and a valid/dirty half
    // (stored with valid/dirty), so a sweep can clear valid/dirty without having
    // to read the tag; their XOR is the even parity over {tag, valid_dirty}.
    assign w_tag_wdata = {^req_tag, req_tag};
    assign w_vd_wdata  = w_sweep ? '0 : {^req_valid_dirty[w], req_valid_dirty[w]};
    assign rsp_parity_err[w] = r_rsp_valid &&
        ((^{w_tag_q[TAG_WIDTH-1:0], w_vd_q[1:0]}) != (w_tag_q[TAG_WIDTH] ^ w_vd_q[2]));
`else
    assign w_tag_wdata = req_tag;
    assign w_vd_wdata  = w_sweep ? '0 : req_valid_dirty[w];
    assign rsp_parity_err[w] = 1'b0;
`endif

    assign w_vd_wen = w_sweep || (w_accept && req_wen_tag[w]);

    cache_sram_bank #(
      .DEPTH  (SETS),
      .WIDTH  (CACHE_LINE_SIZE),
      .STRB_W (STRB_W)
    ) u_data (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ren   (w_accept),
      .i_wen   (w_accept && req_wen_data[w]),
      .i_addr  (w_addr),
      .i_strb  (req_strobe),
      .i_wdata (req_data),
      .o_rdata (rsp_data[w])
    );

    cache_sram_bank #(
      .DEPTH  (SETS),
      .WIDTH  (TAG_SW),
      .STRB_W (1)
    ) u_tag (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ren   (w_accept),
      .i_wen   (w_accept && req_wen_tag[w]),
      .i_addr  (w_addr),
      .i_strb  (1'b1),
      .i_wdata (w_tag_wdata),
      .o_rdata (w_tag_q)
    );

    cache_sram_bank #(
      .DEPTH  (SETS),
      .WIDTH  (VD_SW),
      .STRB_W (1)
    ) u_vd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ren   (w_accept),
      .i_wen   (w_vd_wen),
      .i_addr  (w_addr),
      .i_strb  (1'b1),
      .i_wdata (w_vd_wdata),
      .o_rdata (w_vd_q)
    );

    assign rsp_tag[w]         = w_tag_q[TAG_WIDTH-1:0];
    assign rsp_valid_dirty[w] = w_vd_q[1:0];
  end

endmodule

// File: tb/tb_cache_way_array.sv
// tb/tb_cache_way_array.sv - directed self-checking bench for cache_way_array

module tb_cache_way_array;

  localparam int AW   = 32;
  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int LINE = 64;
  localparam int TW   = AW - ($clog2(SETS) + $clog2(LINE/8));

`ifdef CACHE_WAY_ARRAY_PARITY_EN
  localparam logic [1:0] EXP_PAR = 2'b01;
`else
  localparam logic [1:0] EXP_PAR = 2'b00;
`endif

  logic                        clk;
  logic                        rst_n;
  logic                        req_valid;
  logic                        req_ready;
  logic [AW-1:0]               req_addr;
  logic [WAYS-1:0]             req_wen_data;
  logic [WAYS-1:0]             req_wen_tag;
  logic [LINE/8-1:0]           req_strobe;
  logic [LINE-1:0]             req_data;
  logic [TW-1:0]               req_tag;
  logic [WAYS-1:0][1:0]        req_valid_dirty;
  logic                        rsp_valid;
  logic [WAYS-1:0][LINE-1:0]   rsp_data;
  logic [WAYS-1:0][TW-1:0]     rsp_tag;
  logic [WAYS-1:0][1:0]        rsp_valid_dirty;
  logic [WAYS-1:0]             rsp_parity_err;
  logic                        flush_req;
  logic                        flush_busy;
  logic                        flush_done;

  int checks = 0;
  int errors = 0;

  cache_way_array #(
    .ADDRESS_WIDTH   (AW),
    .SETS            (SETS),
    .WAYS            (WAYS),
    .CACHE_LINE_SIZE (LINE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_wen_data    (req_wen_data),
    .req_wen_tag     (req_wen_tag),
    .req_strobe      (req_strobe),
    .req_data        (req_data),
    .req_tag         (req_tag),
    .req_valid_dirty (req_valid_dirty),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_tag         (rsp_tag),
    .rsp_valid_dirty (rsp_valid_dirty),
    .rsp_parity_err  (rsp_parity_err),
    .flush_req       (flush_req),
    .flush_busy      (flush_busy),
    .flush_done      (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: issue one request (caller sits at posedge+1 in IDLE),
  // return at posedge+1 of the acceptance edge with inputs released.
  task automatic do_req(input logic [3:0] set, input logic [1:0] wd, input logic [1:0] wt,
                        input logic [7:0] strb, input logic [63:0] data, input logic [TW-1:0] tag,
                        input logic [1:0] vd0, input logic [1:0] vd1);
    req_valid          = 1'b1;
    req_addr           = 32'(set) << 3;
    req_wen_data       = wd;
    req_wen_tag        = wt;
    req_strobe         = strb;
    req_data           = data;
    req_tag            = tag;
    req_valid_dirty[0] = vd0;
    req_valid_dirty[1] = vd1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_wen_data = '0;
    req_wen_tag  = '0;
  endtask

  task automatic test_reset;
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || flush_done !== 1'b0 || flush_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp_valid=%b done=%b busy=%b, need 0 0 0 1",
               req_ready, rsp_valid, flush_done, flush_busy);
    end
    checks++;
    if (rsp_data !== '0 || rsp_tag !== '0 || rsp_valid_dirty !== '0 || rsp_parity_err !== '0) begin
      errors++;
      $display("FAIL reset_rsp: data=%h tag=%h vd=%b perr=%b, need all 0",
               rsp_data, rsp_tag, rsp_valid_dirty, rsp_parity_err);
    end
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (flush_done) break;
    end
    checks++;
    if (cyc !== 16 || flush_busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_sweep: cycles=%0d busy=%b ready=%b, need 16 0 1", cyc, flush_busy, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (flush_done !== 1'b0) begin
      errors++;
      $display("FAIL init_done_pulse: done=%b, need 0", flush_done);
    end
    do_req(4'd5, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_valid_dirty !== 4'b0000) begin
      errors++;
      $display("FAIL init_read_set5: rsp_valid=%b vd=%b, need 1 0000", rsp_valid, rsp_valid_dirty);
    end
  endtask

  task automatic test_write_read;
    do_req(4'd3, 2'b10, 2'b10, 8'hFF, 64'h1122334455667788, TW'(25'h5A), 2'b00, 2'b01);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_valid_dirty[1] !== 2'b00) begin
      errors++;
      $display("FAIL read_first: rsp_valid=%b vd1=%b, need 1 00", rsp_valid, rsp_valid_dirty[1]);
    end
    do_req(4'd3, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    checks++;
    if (rsp_tag[1] !== TW'(25'h5A) || rsp_data[1] !== 64'h1122334455667788 ||
        rsp_valid_dirty[1] !== 2'b01 || rsp_valid_dirty[0] !== 2'b00) begin
      errors++;
      $display("FAIL write_read_set3: tag1=%h data1=%h vd1=%b vd0=%b, need 5a 1122334455667788 01 00",
               rsp_tag[1], rsp_data[1], rsp_valid_dirty[1], rsp_valid_dirty[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_tag[1] !== TW'(25'h5A)) begin
      errors++;
      $display("FAIL rsp_hold: rsp_valid=%b tag1=%h, need 0 5a", rsp_valid, rsp_tag[1]);
    end
    do_req(4'd3, 2'b10, 2'b00, 8'h0F, 64'hFFFFFFFFFFFFFFFF, '0, 2'b00, 2'b00);
    do_req(4'd3, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    checks++;
    if (rsp_data[1] !== 64'h11223344FFFFFFFF) begin
      errors++;
      $display("FAIL strobe_0f: data1=%h, need 11223344ffffffff", rsp_data[1]);
    end
    do_req(4'd3, 2'b10, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    do_req(4'd3, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    checks++;
    if (rsp_data[1] !== 64'h11223344FFFFFFFF) begin
      errors++;
      $display("FAIL strobe_zero_noop: data1=%h, need 11223344ffffffff", rsp_data[1]);
    end
  endtask

  task automatic test_back_to_back;
    req_valid          = 1'b1;
    req_addr           = 32'(4) << 3;
    req_wen_data       = 2'b01;
    req_wen_tag        = 2'b01;
    req_strobe         = 8'hFF;
    req_data           = 64'hA5A5A5A5DEADBEEF;
    req_tag            = TW'(25'h11);
    req_valid_dirty[0] = 2'b11;
    req_valid_dirty[1] = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_valid_dirty[0] !== 2'b00) begin
      errors++;
      $display("FAIL b2b_first: rsp_valid=%b vd0=%b, need 1 00", rsp_valid, rsp_valid_dirty[0]);
    end
    req_wen_data = 2'b00;
    req_wen_tag  = 2'b00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag[0] !== TW'(25'h11) || rsp_valid_dirty[0] !== 2'b11 ||
        rsp_data[0] !== 64'hA5A5A5A5DEADBEEF) begin
      errors++;
      $display("FAIL b2b_second: rsp_valid=%b tag0=%h vd0=%b data0=%h, need 1 11 11 a5a5a5a5deadbeef",
               rsp_valid, rsp_tag[0], rsp_valid_dirty[0], rsp_data[0]);
    end
  endtask

  task automatic test_flush_conflict;
    int cyc;
    int ready_seen;
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'(3) << 3;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_wins_ready: ready=%b, need 0", req_ready);
    end
    @(posedge clk); #1;
    flush_req = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || flush_busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_conflict_accept: rsp_valid=%b busy=%b, need 0 1", rsp_valid, flush_busy);
    end
    cyc = 0;
    ready_seen = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (flush_done) break;
      if (req_ready) ready_seen++;
    end
    checks++;
    if (cyc !== 16 || ready_seen !== 0 || flush_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_sweep: cycles=%0d ready_cycles=%0d busy=%b, need 16 0 0", cyc, ready_seen, flush_busy);
    end
    @(posedge clk); #1;
    do_req(4'd3, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    checks++;
    if (rsp_valid_dirty !== 4'b0000 || rsp_data[1] !== 64'h11223344FFFFFFFF || rsp_tag[1] !== TW'(25'h5A)) begin
      errors++;
      $display("FAIL flush_set3: vd=%b data1=%h tag1=%h, need 0000 11223344ffffffff 5a",
               rsp_valid_dirty, rsp_data[1], rsp_tag[1]);
    end
    do_req(4'd4, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    checks++;
    if (rsp_valid_dirty[0] !== 2'b00) begin
      errors++;
      $display("FAIL flush_set4: vd0=%b, need 00", rsp_valid_dirty[0]);
    end
  endtask

  task automatic test_reset_mid_flush;
    int cyc;
    do_req(4'd3, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_data !== '0 || rsp_tag !== '0 || rsp_valid !== 1'b0 || flush_done !== 1'b0 ||
        req_ready !== 1'b0 || flush_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_outputs: data=%h tag=%h rsp_valid=%b done=%b ready=%b busy=%b, need 0 0 0 0 0 1",
               rsp_data, rsp_tag, rsp_valid, flush_done, req_ready, flush_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (flush_done) break;
    end
    checks++;
    if (cyc !== 16 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_init: cycles=%0d ready=%b, need 16 1", cyc, req_ready);
    end
  endtask

  task automatic test_parity;
    do_req(4'd2, 2'b00, 2'b11, 8'h00, 64'h0, TW'(25'h33), 2'b01, 2'b01);
    dut.g_way[0].u_tag.r_mem[2][0] = ~dut.g_way[0].u_tag.r_mem[2][0];
    do_req(4'd2, 2'b00, 2'b00, 8'h00, 64'h0, '0, 2'b00, 2'b00);
    checks++;
    if (rsp_tag[0] !== TW'(25'h32) || rsp_tag[1] !== TW'(25'h33)) begin
      errors++;
      $display("FAIL parity_tags: tag0=%h tag1=%h, need 32 33", rsp_tag[0], rsp_tag[1]);
    end
    checks++;
    if (rsp_parity_err !== EXP_PAR) begin
      errors++;
      $display("FAIL parity_err: perr=%b, need %b", rsp_parity_err, EXP_PAR);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_parity_err !== 2'b00) begin
      errors++;
      $display("FAIL parity_qualified: perr=%b, need 00", rsp_parity_err);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_addr        = '0;
    req_wen_data    = '0;
    req_wen_tag     = '0;
    req_strobe      = '0;
    req_data        = '0;
    req_tag         = '0;
    req_valid_dirty = '0;
    flush_req       = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_flush_conflict();
    test_reset_mid_flush();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
